i2c_angle_responder: RTL
========================

// Module: i2c_angle_responder
// PURPOSE
//   I2C target (responder) modelling the magnetic angle encoder that pwm_ctrl's I2C master polls.
//   Answers address/pointer writes and register reads, returning a coherent 12-bit angle.
//   Drives SDA open-drain (drive-low only).
//   Used as the encoder model in pwm_ctrl system benches and as an FPGA-side encoder emulator.
// PARAMETERS
//   DEV_ADDR    7'h36  7-bit target address matched after START
//   STATUS_VAL  8'h20  value returned for register 0x0B (magnet-detected flag)
//   PTR_RST     8'h0C  pointer value after reset and after each STOP
// PORTS
//   clock       in   1   system clock; must be >= 8x SCL frequency
//   reset_n     in   1   asynchronous, active-low reset
//   scl         in   1   I2C clock from master (asynchronous)
//   sda_in      in   1   I2C data as seen on the wire (asynchronous)
//   sda_oe      out  1   1 = pull SDA low; 0 = release (pad is open-drain)
//   angle       in   12  live encoder angle, 0..4095
//   busy        out  1   high from address match until STOP/NACK/non-matching START
//   snap_pulse  out  1   one-cycle pulse when the angle snapshot is taken
// BEHAVIOUR
//   Reset: sda_oe=0, busy=0, snap_pulse=0, ptr=PTR_RST, state=IDLE, snapshot=0.
//   Input conditioning:
//     - scl and sda_in each pass through a 2-flop synchronizer, then a 1-flop history register.
//     - Edges are detected on the synchronized signals.
//     - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
//     - Data bits are sampled on synchronized SCL rise, MSB first.
//   Output timing:
//     - sda_oe updates only on the cycle after a synchronized SCL fall.
//     - Worst-case pin-to-sda_oe latency is 4 clocks.
//     - sda_oe never changes while synchronized SCL is high, except when forced to 0 by STOP.
//   State machine:
//     IDLE     : sda_oe=0; START -> ADDR.
//     ADDR     : shift 8 bits {addr[6:0], rw}.
//                Match -> A_ACK. Mismatch -> IDLE; busy stays 0.
//     A_ACK    : drive 0 for one SCL period; set busy.
//                rw=1 -> latch snapshot<=angle, pulse snap_pulse, go TX.
//                rw=0 -> PTR.
//     PTR      : shift 8 bits into ptr -> P_ACK.
//     P_ACK    : drive 0 for one SCL period -> WR_IGN.
//     WR_IGN   : later written bytes are ACKed and discarded; ptr += 1 per byte.
//     TX       : drive register[ptr] MSB first; bit value 1 = release, 0 = drive low.
//                After 8th bit: ptr += 1 (8-bit wrap 0xFF->0x00) -> M_ACK.
//     M_ACK    : release SDA; sample master bit on SCL rise.
//                0 (ACK) -> TX next byte. 1 (NACK) -> IDLE, busy=0.
//   Register map (reads):
//     0x0B = STATUS_VAL
//     0x0C = {4'b0, snapshot[11:8]}    0x0D = snapshot[7:0]
//     0x0E = {4'b0, snapshot[11:8]}    0x0F = snapshot[7:0]
//     others = 8'h00
//   Coherence: snapshot updates only at read-address ACK. A multi-byte read never mixes two angles.
//   Boundaries:
//     - START in any state (repeated start): abort current byte, release SDA, -> ADDR; ptr kept.
//     - STOP in any state: -> IDLE, sda_oe=0, busy=0, ptr=PTR_RST.
//     - General-call address 0x00 is not matched.
//     - angle changing mid-transaction has no effect until the next read-address ACK.
//     - reset_n asserted mid-byte: immediate release of SDA, all state to reset values.
// TESTING
//   1. Read 0x6D, angle=12'hA5C, master ACKs byte 1, NACKs byte 2 -> ACK on addr; bytes 0x0A, 0x5C; busy falls after NACK.
//   2. Write 0x6C, 0x0B; repeated START; read 0x6D, 1 byte -> ACK on addr and ptr; returns 0x20.
//   3. Read 0x6D with angle changing every 10 clocks, 2 bytes -> bytes match the value at snap_pulse; exactly one pulse.
//   4. Address 0x70 (mismatch) -> sda_oe stays 0 for the whole transfer; busy=0; no snap_pulse.
//   5. Write ptr=0xFF; read 2 bytes -> 0x00, then STATUS-independent reg 0x00 = 0x00 (ptr wrapped). After STOP, plain read returns angle[11:8].
//   6. reset_n low during TX bit 3 -> sda_oe=0 same cycle; after release, next read starts at ptr=0x0C.

Source files
------------

// File: rtl/i2c_angle_responder.sv
// I2C target emulating a 12-bit magnetic angle encoder: pointer writes, coherent
// multi-byte angle reads from a snapshot taken at the read-address ACK, open-drain SDA.
`timescale 1ns/1ps
module i2c_angle_responder #(
   parameter logic [6:0] DEV_ADDR   = 7'h36,
   parameter logic [7:0] STATUS_VAL = 8'h20,
   parameter logic [7:0] PTR_RST    = 8'h0C
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        scl,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [11:0] angle,
   output logic        busy,
   output logic        snap_pulse
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_A_ACK, S_PTR, S_P_ACK, S_WR_IGN, S_TX, S_M_ACK
   } state_t;

   logic        r_scl_meta, r_scl_sync, r_scl_hist;
   logic        r_sda_meta, r_sda_sync, r_sda_hist;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_ptr;
   logic [11:0] r_snapshot;
   logic        r_rw;
   logic        r_sda_oe;
   logic        r_busy;
   logic        r_snap_pulse;

   state_t      w_state_nxt;
   logic [3:0]  w_cnt_nxt;
   logic [7:0]  w_shift_nxt;
   logic [7:0]  w_ptr_nxt;
   logic [11:0] w_snap_nxt;
   logic        w_rw_nxt;
   logic        w_oe_nxt;
   logic        w_busy_nxt;
   logic        w_pulse_nxt;

   logic        w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
   logic [7:0]  w_shift_in;
   logic [7:0]  w_rd_byte;

   function automatic logic [7:0] reg_read(input logic [7:0] p, input logic [11:0] snap);
      case (p)
         8'h0B:        reg_read = STATUS_VAL;
         8'h0C, 8'h0E: reg_read = {4'b0000, snap[11:8]};
         8'h0D, 8'h0F: reg_read = snap[7:0];
         default:      reg_read = 8'h00;
      endcase
   endfunction

   // NOTE: synchronizers reset to 1 (idle bus) so leaving reset never fakes a START or edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_hist <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_meta <= scl;
         r_scl_sync <= r_scl_meta;
         r_scl_hist <= r_scl_sync;
         r_sda_meta <= sda_in;
         r_sda_sync <= r_sda_meta;
         r_sda_hist <= r_sda_sync;
      end
   end

   assign w_scl_rise  = r_scl_sync & ~r_scl_hist;
   assign w_scl_fall  = ~r_scl_sync & r_scl_hist;
   assign w_start     = r_scl_sync & r_scl_hist & r_sda_hist & ~r_sda_sync;
   assign w_stop      = r_scl_sync & r_scl_hist & ~r_sda_hist & r_sda_sync;
   assign w_byte_done = w_scl_fall && (r_cnt == 4'd8);
   assign w_shift_in  = {r_shift[6:0], r_sda_sync};
   assign w_rd_byte   = reg_read(r_ptr, r_snapshot);

   // Bus-side transitions land on synchronized SCL edges so sda_oe only moves while SCL is low.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_ptr_nxt   = r_ptr;
      w_snap_nxt  = r_snapshot;
      w_rw_nxt    = r_rw;
      w_oe_nxt    = r_sda_oe;
      w_busy_nxt  = r_busy;
      w_pulse_nxt = 1'b0;

      if (w_stop) begin
         w_state_nxt = S_IDLE;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b0;
         w_ptr_nxt   = PTR_RST;
      end else if (w_start) begin
         w_state_nxt = S_ADDR;
         w_cnt_nxt   = 4'd0;
         w_oe_nxt    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: w_oe_nxt = 1'b0;
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_shift_in;
                  w_cnt_nxt   = r_cnt + 4'd1;
               end else if (w_byte_done) begin
                  w_cnt_nxt = 4'd0;
                  if (r_shift[7:1] == DEV_ADDR && r_shift[7:1] != 7'd0) begin
                     w_state_nxt = S_A_ACK;
                     w_oe_nxt    = 1'b1;
                     w_busy_nxt  = 1'b1;
                     w_rw_nxt    = r_shift[0];
                     if (r_shift[0]) begin
                        w_snap_nxt  = angle;
                        w_pulse_nxt = 1'b1;
                     end
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end
            end
            S_A_ACK: begin
               if (w_scl_fall) begin
                  w_cnt_nxt = 4'd0;
                  if (r_rw) begin
                     w_state_nxt = S_TX;
                     w_shift_nxt = w_rd_byte;
                     w_oe_nxt    = ~w_rd_byte[7];
                  end else begin
                     w_state_nxt = S_PTR;
                     w_oe_nxt    = 1'b0;
                  end
               end
            end
            S_PTR, S_WR_IGN: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_shift_in;
                  w_cnt_nxt   = r_cnt + 4'd1;
               end else if (w_byte_done) begin
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = S_P_ACK;
                  w_oe_nxt    = 1'b1;
                  w_ptr_nxt   = (r_state == S_PTR) ? r_shift : r_ptr + 8'd1;
               end
            end
            S_P_ACK: begin
               if (w_scl_fall) begin
                  w_state_nxt = S_WR_IGN;
                  w_cnt_nxt   = 4'd0;
                  w_oe_nxt    = 1'b0;
               end
            end
            S_TX: begin
               if (w_scl_rise) begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end else if (w_byte_done) begin
                  w_state_nxt = S_M_ACK;
                  w_oe_nxt    = 1'b0;
                  w_ptr_nxt   = r_ptr + 8'd1;
               end else if (w_scl_fall) begin
                  w_shift_nxt = {r_shift[6:0], 1'b0};
                  w_oe_nxt    = ~r_shift[6];
               end
            end
            S_M_ACK: begin
               if (w_scl_rise && r_sda_sync) begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
               end else if (w_scl_fall) begin
                  w_state_nxt = S_TX;
                  w_cnt_nxt   = 4'd0;
                  w_shift_nxt = w_rd_byte;
                  w_oe_nxt    = ~w_rd_byte[7];
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_oe_nxt    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_shift      <= 8'h00;
         r_ptr        <= PTR_RST;
         r_snapshot   <= 12'h000;
         r_rw         <= 1'b0;
         r_sda_oe     <= 1'b0;
         r_busy       <= 1'b0;
         r_snap_pulse <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_ptr        <= w_ptr_nxt;
         r_snapshot   <= w_snap_nxt;
         r_rw         <= w_rw_nxt;
         r_sda_oe     <= w_oe_nxt;
         r_busy       <= w_busy_nxt;
         r_snap_pulse <= w_pulse_nxt;
      end
   end

   assign sda_oe     = r_sda_oe;
   assign busy       = r_busy;
   assign snap_pulse = r_snap_pulse;

endmodule
